rsa_host_ctrl: RTL and testbench
================================

Name: rsa_host_ctrl

Overview:
- Sequencer between a byte-stream host port (UART/USB bridge) and the 256-bit RSA exponentiation core.
- Collects 96 operand bytes and writes them into the core's byte-addressed operand registers: modulus, base, exponent.
- Triggers the computation, waits for completion, reads the 32-byte result back and streams it out.
- Sole master of the core's register bus; no other block drives that bus.

Parameters:
- NBYTES, 32, bytes per operand (and per result); addr width is clog2(NBYTES)=5.
- TIMEOUT_CYC, 200000, maximum compute cycles before error (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- abort  in  1  synchronous cancel; returns to IDLE
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  controller accepts a byte
- out_valid  out  1  result byte valid
- out_data  out  8  result byte
- out_ready  in  1  host accepts a result byte
- core_we_n  out  1  core write strobe, active low
- core_oe_n  out  1  core read strobe, active low
- core_reg_sel  out  2  core register select: 3=modulus, 1=base, 2=exponent, 0=result
- core_addr  out  5  byte index within the operand, 0 = least-significant byte
- core_wdata  out  8  write data
- core_rdata  in  8  read data, valid 1 cycle after core_oe_n low
- core_start  out  1  one-cycle start pulse
- core_busy  in  1  core computing
- busy  out  1  controller not in IDLE
- done  out  1  one-cycle pulse after the last result byte handshake
- err  out  1  sticky error flag; cleared by reset or by the next accepted byte in IDLE

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0, out_valid=0, out_data=0, core_we_n=1, core_oe_n=1, core_reg_sel=0, core_addr=0, core_wdata=0, core_start=0, busy=0, done=0, err=0. Byte counter=0, state=IDLE.
- in_ready rises the cycle after reset deasserts.
- States: IDLE, LOAD, START, WAIT_BUSY, COMPUTE, RD_REQ, RD_CAP, SEND.
- IDLE and LOAD:
  - in_ready=1.
  - On each in_valid&in_ready handshake, the next cycle drives core_we_n=0 for exactly 1 cycle, with core_wdata=in_data.
  - Register select by byte count cnt: cnt 0-31 -> sel 3, cnt 32-63 -> sel 1, cnt 64-95 -> sel 2; core_addr=cnt[4:0].
  - Back-to-back handshakes are allowed: 1 byte per cycle.
  - The first handshake moves IDLE->LOAD.
  - The handshake at cnt=95 moves to START; in_ready drops the following cycle.
- START: core_start=1 for exactly 1 cycle, then -> WAIT_BUSY.
- WAIT_BUSY: stay until core_busy=1, then -> COMPUTE.
- COMPUTE: stay until core_busy=0, then -> RD_REQ with cnt=0.
- RD_REQ: core_oe_n=0 for 1 cycle with sel=0, addr=cnt[4:0]; -> RD_CAP.
- RD_CAP: out_data<=core_rdata, out_valid<=1; -> SEND.
- SEND:
  - Hold out_valid and out_data stable until out_ready.
  - On the handshake: out_valid drops the next cycle, cnt increments.
  - cnt<31 -> RD_REQ; cnt=31 -> IDLE with done=1 for 1 cycle and cnt cleared.
  - Result byte order is LSB first.
- Strobe exclusivity: core_we_n and core_oe_n are never both low. core_start is never high while either strobe is low.
- abort:
  - From any state, the next edge gives state=IDLE, cnt=0.
  - Strobes deasserted, out_valid=0, core_start=0, err unchanged.
  - A byte handshake coincident with abort is discarded.
  - reset has priority over abort.
- Reset mid-operation: identical to the reset values above. The core's partial state is ignored; the next session reloads all 96 bytes.
- busy = (state != IDLE).
- cnt is 7 bits and never exceeds 95.

Optional Feature:
- Macro: RSA_CTRL_TIMEOUT_EN.
- When defined: a cycle counter runs in WAIT_BUSY and COMPUTE. If it reaches TIMEOUT_CYC, then err<=1 and state goes to IDLE with no result readout.
  - The counter clears on entering WAIT_BUSY.
- When undefined: no counter exists, err stays 0 permanently, and WAIT_BUSY/COMPUTE wait indefinitely.

Test Plan:
- Load path:
  - Stimulus: stream 96 bytes 0x00..0x5F back-to-back.
  - Required: 96 single-cycle core_we_n pulses.
  - Byte 0x00 -> sel3/addr0; 0x1F -> sel3/addr31; 0x20 -> sel1/addr0; 0x5F -> sel2/addr31.
  - core_start pulses once, 2 cycles after the last write strobe.
- Compute and readback:
  - Stimulus: core model asserts busy 3 cycles after start, holds it 500 cycles, returns rdata=addr^0xA5; out_ready tied 1.
  - Required: 32 out bytes 0xA5,0xA4,...,0xBA, each preceded by one core_oe_n pulse; done pulses once; busy=0 afterwards.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles on byte 5.
  - Required: out_data=0xA0 held stable; no extra core_oe_n pulses during the stall.
- Abort:
  - Stimulus: assert abort at load byte 40.
  - Required: IDLE next cycle; the next session's first byte writes sel3/addr0.
- Reset:
  - Stimulus: assert reset during SEND at byte 10.
  - Required: all outputs at their reset values after the edge; in_ready=1 one cycle after reset deasserts.
- Timeout (RSA_CTRL_TIMEOUT_EN defined, TIMEOUT_CYC=100):
  - Stimulus: core_busy never falls.
  - Required: err=1 and IDLE 100 cycles after entering WAIT_BUSY; no out_valid; err clears on the next accepted byte.

Source files
------------

// File: rtl/rsa_host_ctrl.sv
// rsa_host_ctrl: sequencer between a byte-stream host port and the 256-bit RSA core.
// Latency: one register stage from each host byte to its core write strobe; each result byte
//   takes read request, capture and send cycles, plus any host stall.
// Backpressure: in_ready is high only in IDLE/LOAD; out_valid/out_data hold until out_ready.
//
// Ports: clk/reset (sync, active-high), abort (sync cancel to IDLE)
//   host in : in_valid/in_data/in_ready   - 96 operand bytes: modulus, base, exponent, LSB first
//   host out: out_valid/out_data/out_ready - 32 result bytes, LSB first
//   core    : core_we_n/core_oe_n strobes, core_reg_sel, core_addr, core_wdata, core_rdata,
//             core_start pulse, core_busy
//   status  : busy (not IDLE), done (pulse after last result byte), err (sticky watchdog flag)
// Optional: define RSA_CTRL_TIMEOUT_EN to add a compute watchdog of TIMEOUT_CYC cycles.
//   Without it err is constant 0 and the controller waits on core_busy indefinitely.
module rsa_host_ctrl #(
  parameter int NBYTES = 32
`ifdef RSA_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 200000
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  input  logic                      out_ready,
  output logic                      core_we_n,
  output logic                      core_oe_n,
  output logic [1:0]                core_reg_sel,
  output logic [$clog2(NBYTES)-1:0] core_addr,
  output logic [7:0]                core_wdata,
  input  logic [7:0]                core_rdata,
  output logic                      core_start,
  input  logic                      core_busy,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int         AW       = $clog2(NBYTES);
  localparam logic [6:0] LAST_OP  = 7'(3 * NBYTES - 1);
  localparam logic [6:0] LAST_RES = 7'(NBYTES - 1);

  localparam logic [1:0] SEL_RES  = 2'd0;
  localparam logic [1:0] SEL_BASE = 2'd1;
  localparam logic [1:0] SEL_EXP  = 2'd2;
  localparam logic [1:0] SEL_MOD  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_BUSY, COMPUTE, RD_REQ, RD_CAP, SEND
  } state_t;

  state_t          state, state_d;
  logic [6:0]      cnt, cnt_d;
  logic            in_ready_d, out_valid_d, we_n_d, oe_n_d, start_d, busy_d, done_d, err_d;
  logic [7:0]      out_data_d, wdata_d;
  logic [1:0]      sel_d;
  logic [AW-1:0]   addr_d;
  logic            in_hs, out_hs, tmo_hit;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Operand order on the host stream is modulus, base, exponent.
  function automatic logic [1:0] op_sel(input logic [6:0] c);
    logic [1:0] s;
    if (c < 7'(NBYTES))          s = SEL_MOD;
    else if (c < 7'(2 * NBYTES)) s = SEL_BASE;
    else                         s = SEL_EXP;
    return s;
  endfunction

`ifdef RSA_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Counter holds TIMEOUT_CYC-1 on the edge that is TIMEOUT_CYC cycles after WAIT_BUSY entry.
  assign tmo_hit = ((state == WAIT_BUSY) || (state == COMPUTE)) &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset)
      tmo_cnt <= '0;
    else if ((state_d == WAIT_BUSY) && (state != WAIT_BUSY))
      tmo_cnt <= '0;
    else if ((state == WAIT_BUSY) || (state == COMPUTE))
      tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    sel_d       = core_reg_sel;
    addr_d      = core_addr;
    wdata_d     = core_wdata;
    start_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = err;

    if (abort) begin
      // Any coincident host byte is dropped: no strobe, counter cleared.
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else if (tmo_hit) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (in_hs) begin
            we_n_d  = 1'b0;
            wdata_d = in_data;
            sel_d   = op_sel(cnt);
            addr_d  = cnt[AW-1:0];
            if (state == IDLE) err_d = 1'b0;
            if (cnt == LAST_OP) begin
              state_d = START;
            end else begin
              cnt_d   = cnt + 7'd1;
              state_d = LOAD;
            end
          end
        end
        START: begin
          // Wait for the last write strobe to retire so the bus has an idle cycle
          // between the final operand write and the start pulse.
          if (core_we_n) begin
            start_d = 1'b1;
            state_d = WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (core_busy) state_d = COMPUTE;
        end
        COMPUTE: begin
          if (!core_busy) begin
            state_d = RD_REQ;
            cnt_d   = '0;
            oe_n_d  = 1'b0;
            sel_d   = SEL_RES;
            addr_d  = '0;
          end
        end
        RD_REQ: begin
          state_d = RD_CAP;
        end
        RD_CAP: begin
          out_data_d  = core_rdata;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
        SEND: begin
          if (out_hs) begin
            out_valid_d = 1'b0;
            if (cnt == LAST_RES) begin
              state_d = IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d   = cnt + 7'd1;
              state_d = RD_REQ;
              oe_n_d  = 1'b0;
              sel_d   = SEL_RES;
              addr_d  = cnt_d[AW-1:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      core_we_n    <= 1'b1;
      core_oe_n    <= 1'b1;
      core_reg_sel <= '0;
      core_addr    <= '0;
      core_wdata   <= '0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      in_ready     <= in_ready_d;
      out_valid    <= out_valid_d;
      out_data     <= out_data_d;
      core_we_n    <= we_n_d;
      core_oe_n    <= oe_n_d;
      core_reg_sel <= sel_d;
      core_addr    <= addr_d;
      core_wdata   <= wdata_d;
      core_start   <= start_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// tb_rsa_host_ctrl: randomized self-checking bench for rsa_host_ctrl with a behavioural
// RSA-core register model and a host-side reference of the expected bus writes and results.
`timescale 1ns/1ps
module tb_rsa_host_ctrl;
  localparam int NB = 32;

  logic       clk = 1'b0, reset = 1'b1, abort = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b1, core_busy = 1'b0;
  logic [7:0] in_data = 8'h00, core_rdata = 8'h00;
  logic       in_ready, out_valid, core_we_n, core_oe_n, core_start, busy, done, err;
  logic [7:0] out_data, core_wdata;
  logic [1:0] core_reg_sel;
  logic [4:0] core_addr;

  rsa_host_ctrl #(
    .NBYTES(NB)
`ifdef RSA_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_we_n(core_we_n), .core_oe_n(core_oe_n), .core_reg_sel(core_reg_sel),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_start(core_start), .core_busy(core_busy),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [7:0]  op [96];
  logic [7:0]  res_mem [NB];
  logic [14:0] wr_q [$];
  logic [7:0]  out_q [$];
  int cyc = 0, last_we_cyc = 0, start_cyc = 0, start_cnt = 0, oe_cnt = 0, oe_bad = 0;
  int done_cnt = 0, excl_viol = 0, hold_viol = 0, ov_cnt = 0, stall_cyc = 0, drv_to = 0;
  bit hold_pend = 0;
  logic [7:0] hold_dat = 8'h00;

  // Core model: busy rises 3 cycles after the start pulse and lasts busy_len cycles.
  int ph = -1;
  int busy_len = 500;
  bit busy_stuck = 0;
  always @(posedge clk) begin
    if (reset || abort)  ph <= -1;
    else if (core_start) ph <= 0;
    else if (ph >= 0)    ph <= ph + 1;
    core_busy <= busy_stuck || (ph >= 1 && ph < 1 + busy_len);
    if (!core_oe_n) core_rdata <= res_mem[core_addr];
  end

  // Bus/host monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (!core_we_n) begin
        wr_q.push_back({core_reg_sel, core_addr, core_wdata});
        last_we_cyc = cyc;
      end
      if (!core_oe_n) begin
        oe_cnt++;
        if (core_reg_sel !== 2'd0) oe_bad++;
      end
      if (core_start) begin start_cnt++; start_cyc = cyc; end
      if (done) done_cnt++;
      if ((!core_we_n && !core_oe_n) || (core_start && (!core_we_n || !core_oe_n))) excl_viol++;
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (out_valid && !out_ready) stall_cyc++;
      if (out_valid) ov_cnt++;
      if (hold_pend && (!out_valid || out_data !== hold_dat)) hold_viol++;
    end
    hold_pend = out_valid && !out_ready && !reset && !abort;
    hold_dat  = out_data;
  end

  function automatic logic [14:0] exp_wr(input int i);
    logic [1:0] s;
    s = (i < 32) ? 2'd3 : ((i < 64) ? 2'd1 : 2'd2);
    return {s, 5'(i % 32), op[i]};
  endfunction

  task automatic clr_mon();
    wr_q.delete(); out_q.delete();
    start_cnt = 0; oe_cnt = 0; oe_bad = 0; done_cnt = 0; excl_viol = 0;
    hold_viol = 0; ov_cnt = 0; stall_cyc = 0; drv_to = 0;
  endtask

  task automatic load_bytes(input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = op[i];
      begin
        int  g;
        bit  acc;
        g = 0;
        do begin
          @(negedge clk); acc = in_ready;
          @(posedge clk); #1; g++;
        end while (!acc && g < 200);
        if (!acc) drv_to++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit rnd, input int stall_idx, input int stall_len);
    int guard;
    int stalled;
    guard = 0; stalled = 0;
    while (out_q.size() < n && guard < 3000) begin
      if (out_q.size() == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        if (out_valid) stalled++;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1; guard++;
    end
    out_ready = 1'b1;
    if (out_q.size() < n) drv_to++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, out_data, core_we_n, core_oe_n, core_reg_sel, core_addr, core_wdata,
         core_start, busy, done, err} !== {2'b00, 8'h00, 2'b11, 2'b00, 5'h00, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h", {in_ready, out_valid, out_data, core_we_n,
               core_oe_n, core_reg_sel, core_addr, core_wdata, core_start, busy, done, err},
               {2'b00, 8'h00, 2'b11, 2'b00, 5'h00, 8'h00, 4'b0000});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_rise: got %b want 1", in_ready); end
  endtask

  task automatic test_load_readback();
    clr_mon();
    for (int i = 0; i < 96; i++) op[i] = 8'(i);
    for (int i = 0; i < NB; i++) res_mem[i] = 8'(i) ^ 8'hA5;
    busy_len = 500;
    load_bytes(0, 96, 1'b0);
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (wr_q.size() !== 96) begin n_fail++; $display("FAIL load_we_count: got %0d want 96", wr_q.size()); end
    for (int i = 0; i < 96 && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i] !== exp_wr(i)) begin
        n_fail++; $display("FAIL load_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr(i));
      end
    end
    n_checks++;
    if (start_cnt !== 1) begin n_fail++; $display("FAIL load_start_count: got %0d want 1", start_cnt); end
    n_checks++;
    if (start_cyc - last_we_cyc !== 2) begin
      n_fail++; $display("FAIL load_start_gap: got %0d want 2", start_cyc - last_we_cyc);
    end
    collect(NB, 1'b0, -1, 0);
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (drv_to !== 0) begin n_fail++; $display("FAIL readback_timeout: got %0d want 0", drv_to); end
    for (int i = 0; i < NB && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== (8'(i) ^ 8'hA5)) begin
        n_fail++; $display("FAIL readback_byte[%0d]: got %h want %h", i, out_q[i], 8'(i) ^ 8'hA5);
      end
    end
    n_checks++;
    if (oe_cnt !== NB || oe_bad !== 0) begin
      n_fail++; $display("FAIL readback_oe: got %0d pulses (%0d bad sel) want 32", oe_cnt, oe_bad);
    end
    n_checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL readback_done: got done=%0d busy=%b want 1/0", done_cnt, busy);
    end
    n_checks++;
    if (excl_viol !== 0 || err !== 1'b0) begin
      n_fail++; $display("FAIL readback_strobe_excl: got viol=%0d err=%b want 0/0", excl_viol, err);
    end
  endtask

  task automatic test_backpressure();
    clr_mon();
    busy_len = 20;
    load_bytes(0, 96, 1'b0);
    collect(NB, 1'b0, 5, 10);
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (out_q.size() !== NB || out_q[5] !== 8'hA0) begin
      n_fail++; $display("FAIL bp_byte5: got size=%0d byte=%h want 32/a0", out_q.size(), out_q[5]);
    end
    n_checks++;
    if (stall_cyc !== 10 || hold_viol !== 0) begin
      n_fail++; $display("FAIL bp_hold: got stall=%0d viol=%0d want 10/0", stall_cyc, hold_viol);
    end
    n_checks++;
    if (oe_cnt !== NB || done_cnt !== 1) begin
      n_fail++; $display("FAIL bp_oe: got oe=%0d done=%0d want 32/1", oe_cnt, done_cnt);
    end
  endtask

  task automatic test_abort();
    clr_mon();
    for (int i = 0; i < 96; i++) op[i] = 8'($urandom);
    load_bytes(0, 40, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_data = op[40];
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || core_we_n !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b we_n=%b in_ready=%b want 0/1/1", busy, core_we_n, in_ready);
    end
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (wr_q.size() !== 40) begin n_fail++; $display("FAIL abort_discard: got %0d writes want 40", wr_q.size()); end
    clr_mon();
    for (int i = 0; i < 96; i++) op[i] = 8'($urandom);
    for (int i = 0; i < NB; i++) res_mem[i] = 8'($urandom);
    busy_len = 15;
    load_bytes(0, 96, 1'b1);
    collect(NB, 1'b1, -1, 0);
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (wr_q.size() === 0 || wr_q[0] !== {2'd3, 5'd0, op[0]}) begin
      n_fail++; $display("FAIL abort_reload_first: got %h want %h", wr_q.size() ? wr_q[0] : 15'h0, {2'd3, 5'd0, op[0]});
    end
    for (int i = 0; i < NB && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== res_mem[i]) begin
        n_fail++; $display("FAIL abort_reload_res[%0d]: got %h want %h", i, out_q[i], res_mem[i]);
      end
    end
    n_checks++;
    if (out_q.size() !== NB || done_cnt !== 1) begin
      n_fail++; $display("FAIL abort_reload_done: got n=%0d done=%0d want 32/1", out_q.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    clr_mon();
    busy_len = 10;
    load_bytes(0, 96, 1'b0);
    collect(10, 1'b0, -1, 0);
    out_ready = 1'b0;
    g = 0;
    while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_send: got %b want 1", out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, out_data, core_we_n, core_oe_n, core_reg_sel, core_addr, core_wdata,
         core_start, busy, done, err} !== {2'b00, 8'h00, 2'b11, 2'b00, 5'h00, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL rstmid_values: got %h want %h", {in_ready, out_valid, out_data, core_we_n,
               core_oe_n, core_reg_sel, core_addr, core_wdata, core_start, busy, done, err},
               {2'b00, 8'h00, 2'b11, 2'b00, 5'h00, 8'h00, 4'b0000});
    end
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_in_ready: got in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    clr_mon();
    load_bytes(0, 1, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (wr_q.size() !== 1 || wr_q[0] !== {2'd3, 5'd0, op[0]}) begin
      n_fail++; $display("FAIL rstmid_reload: got n=%0d wr=%h want 1/%h", wr_q.size(), wr_q[0], {2'd3, 5'd0, op[0]});
    end
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 3; it++) begin
      clr_mon();
      for (int i = 0; i < 96; i++) op[i] = 8'($urandom);
      for (int i = 0; i < NB; i++) res_mem[i] = 8'($urandom);
      busy_len = $urandom_range(1, 40);
      load_bytes(0, 96, it != 0);
      collect(NB, 1'b1, -1, 0);
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if (wr_q.size() !== 96 || out_q.size() !== NB) begin
        n_fail++; $display("FAIL b2b_counts[%0d]: got wr=%0d out=%0d want 96/32", it, wr_q.size(), out_q.size());
      end
      for (int i = 0; i < 96 && i < wr_q.size(); i++) begin
        n_checks++;
        if (wr_q[i] !== exp_wr(i)) begin
          n_fail++; $display("FAIL b2b_wr[%0d][%0d]: got %h want %h", it, i, wr_q[i], exp_wr(i));
        end
      end
      for (int i = 0; i < NB && i < out_q.size(); i++) begin
        n_checks++;
        if (out_q[i] !== res_mem[i]) begin
          n_fail++; $display("FAIL b2b_res[%0d][%0d]: got %h want %h", it, i, out_q[i], res_mem[i]);
        end
      end
      n_checks++;
      if (start_cnt !== 1 || done_cnt !== 1 || oe_cnt !== NB || excl_viol !== 0 || hold_viol !== 0) begin
        n_fail++; $display("FAIL b2b_protocol[%0d]: got start=%0d done=%0d oe=%0d excl=%0d hold=%0d want 1/1/32/0/0",
                           it, start_cnt, done_cnt, oe_cnt, excl_viol, hold_viol);
      end
    end
  endtask

  task automatic test_watchdog();
    int g;
    clr_mon();
    busy_stuck = 1;
    load_bytes(0, 96, 1'b0);
`ifdef RSA_CTRL_TIMEOUT_EN
    g = 0;
    while (start_cnt == 0 && g < 20) begin @(negedge clk); g++; end
    while (cyc < start_cyc + 99 && g < 300) begin @(negedge clk); g++; end
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_before: got busy=%b err=%b want 1/0", busy, err);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b1 || ov_cnt !== 0) begin
      n_fail++; $display("FAIL tmo_fire: got busy=%b err=%b ov=%0d want 0/1/0", busy, err, ov_cnt);
    end
    @(posedge clk); #1;
    load_bytes(0, 1, 1'b0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b want 0", err); end
`else
    g = 0;
    repeat (300) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0 || ov_cnt !== 0 || oe_cnt !== 0) begin
      n_fail++; $display("FAIL stuck_wait: got busy=%b err=%b ov=%0d oe=%0d want 1/0/0/0", busy, err, ov_cnt, oe_cnt);
    end
`endif
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    busy_stuck = 0;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL watchdog_exit: got busy=%b err=%b want 0/0", busy, err);
    end
  endtask

  initial begin
    test_reset();
    test_load_readback();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, got t=%0t want done", $time);
    $fatal(1, "timeout");
  end

endmodule
